gmem_m_axi_fifo_flex: RTL and testbench
=======================================

# gmem_m_axi_fifo_flex

Parametrised first-word-fall-through FIFO for the m_axi adapter data, address and response paths; next generation of the adapter FIFO. It adds programmable almost-full/almost-empty flags, a synchronous flush, sticky overflow/underflow error flags and a selectable storage style. Depth is fully parameterised, including non-power-of-two. It sits between the kernel-side request logic and the AXI channel slices. The output is always registered.

## Interface
- DATA_WIDTH, 32, word width in bits (>=1)
- DEPTH, 32, total capacity in words, including the output register (>=2, any integer)
- ADDR_WIDTH, 5, equals clog2(DEPTH); the count port is ADDR_WIDTH+1 bits
- MEM_STYLE, "auto", storage style: "auto", "block", "distributed" or "shiftreg"
- AF_THRESH, DEPTH-2, almost-full asserts when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 1, almost-empty asserts when count <= AE_THRESH (0..DEPTH-1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- clk_en  in  1  global enable; when low, all state is frozen and outputs hold
- flush  in  1  synchronous clear of contents; error flags are kept
- if_full_n  out  1  ready to accept a word
- if_write  in  1  write request
- if_din  in  DATA_WIDTH  write data
- if_empty_n  out  1  if_dout is valid
- if_read  in  1  read/acknowledge of if_dout
- if_dout  out  DATA_WIDTH  head word, registered
- if_num_data_valid  out  ADDR_WIDTH+1  count of words held
- if_almost_full  out  1  count >= AF_THRESH
- if_almost_empty  out  1  count <= AE_THRESH
- err_overflow  out  1  sticky: a write was attempted while full
- err_underflow  out  1  sticky: a read was attempted while empty

## Operation
- push = if_write & if_full_n & ~flush. Pop = if_read & if_empty_n & ~flush. All updates are qualified by clk_en.
- count = words accepted and not yet popped, in the range 0..DEPTH.
  - push & ~pop: count+1.
  - pop & ~push: count-1.
  - both, or neither: count unchanged.
- Storage is an internal ring of DEPTH-1 entries plus the output register.
  - Ring pointers wrap from DEPTH-2 to 0; no power-of-two arithmetic.
- Bypass: if the ring is empty and the output register is empty or being popped, the pushed word loads the output register directly.
- Otherwise the pushed word goes to the ring. The output register refills from the ring on the cycle after it empties or is popped.
- Ordering is strictly FIFO under every combination of push, pop and bypass.
- Ignored requests:
  - if_write while !if_full_n is ignored and sets err_overflow.
  - if_read while !if_empty_n is ignored and sets err_underflow.
- flush: count, pointers, if_empty_n, if_almost_full go to 0; if_full_n, if_almost_empty go to 1; same-cycle write/read are discarded. Error flags are not cleared.
- reset does everything flush does and also clears both error flags.
- if_dout is not specified while if_empty_n=0. It changes only on a load.

## Timing
- Reset and flush values:
  - if_full_n=1, if_empty_n=0, if_num_data_valid=0.
  - if_almost_full=0, if_almost_empty=1 (for AE_THRESH>=0).
  - err_*=0 (reset only).
- All outputs are registered. Flags are computed from the next count, so they are exact on the cycle after the event.
- Write-to-read latency is 1 cycle: a push at edge N gives if_empty_n=1 and valid if_dout after edge N.
- Throughput is 1 word/cycle in and 1 word/cycle out sustained, including when full (pop frees space; if_full_n rises the next cycle).
- Full: if_full_n=0 exactly when count==DEPTH. A write while full, with a same-cycle read, is still rejected; there is no pass-through.
- Empty with simultaneous write and read: the read is ignored (if_empty_n=0); the write is accepted.
- clk_en=0: no state changes, including error flags.

## Structure
- Package gmem_m_axi_fifo_pkg holds:
  - MEM_STYLE string constants;
  - a clog2 function;
  - a threshold-validation function. Out-of-range AF_THRESH/AE_THRESH or DEPTH<2 is an elaboration error.
- Sub-module gmem_m_axi_fifo_ram: DEPTH-1 entry storage with 1-cycle registered read, a ram_style attribute driven by MEM_STYLE, and an SRL implementation for "shiftreg".
- The top level holds the pointers, count, bypass/refill control and flags.

## Test plan
- Fill/drain, DEPTH=5, AF_THRESH=4, AE_THRESH=1:
  - write 0x10..0x14 back-to-back: if_full_n=0 after the 5th, count=5, almost_full after the 4th;
  - read all five: data 0x10..0x14 in order, then if_empty_n=0, almost_empty at count<=1.
- Bypass latency: from empty, write 0xA5: if_empty_n=1 and if_dout=0xA5 one cycle later, count=1.
- Streaming: continuous write and read for 100 cycles at count=3: count stays 3, no bubbles, sequence intact across ring wrap (non-power-of-two DEPTH=5).
- Errors:
  - write while full sets err_overflow and leaves contents intact;
  - read while empty sets err_underflow;
  - flush keeps both flags; reset clears them.
- Flush mid-stream with count=3 and a same-cycle write: next cycle count=0, if_empty_n=0; a subsequent write 0x77 reads back as 0x77.
- clk_en low for 4 cycles during active traffic: all outputs hold; traffic resumes without loss or duplication.

Source files
------------

// File: rtl/gmem_m_axi_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the m_axi adapter FIFO.
//   - storage style names accepted by MEM_STYLE
//   - clog2 / ring pointer width helpers
//   - parameter validation used to reject bad configurations at elaboration
package gmem_m_axi_fifo_pkg;

  localparam string MemStyleAuto        = "auto";
  localparam string MemStyleBlock       = "block";
  localparam string MemStyleDistributed = "distributed";
  localparam string MemStyleShiftreg    = "shiftreg";

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Ring holds depth-1 words; keep at least one pointer bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 2) ? 1 : clog2(depth - 1);
  endfunction

  function automatic bit params_ok(input int unsigned depth, input int unsigned addr_width,
                                   input int unsigned af, input int unsigned ae);
    return (depth >= 2) && (addr_width == clog2(depth)) &&
           (af >= 1) && (af <= depth) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/gmem_m_axi_fifo_ram.sv
// Ring storage for the adapter FIFO plus the registered output word.
//   clk         clock
//   we/waddr    ring write strobe and address; wdata is the write word
//   load        load the output register this cycle
//   bypass      on load, take wdata instead of the ring word at raddr
//   raddr       ring read address (for "shiftreg", the tap of the oldest word)
//   dout        registered output word
module gmem_m_axi_fifo_ram
  import gmem_m_axi_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WORDS      = 31,
  parameter int unsigned PTR_WIDTH  = 5,
  parameter string       MEM_STYLE  = "auto"
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PTR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  load,
  input  logic                  bypass,
  input  logic [PTR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] rd_word;

  if (MEM_STYLE == MemStyleShiftreg) begin : gen_srl
    // Shift in at tap 0; the oldest word sits at tap (ring count - 1).
    (* shreg_extract = "yes" *) logic [DATA_WIDTH-1:0] sr [WORDS];
    always_ff @(posedge clk) begin
      if (we) begin
        sr[0] <= wdata;
        for (int i = 1; i < int'(WORDS); i++) sr[i] <= sr[i-1];
      end
    end
    assign rd_word = sr[raddr];
  end else if (MEM_STYLE == MemStyleBlock) begin : gen_block
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [WORDS];
    always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
    assign rd_word = mem[raddr];
  end else if (MEM_STYLE == MemStyleDistributed) begin : gen_dist
    (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [WORDS];
    always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
    assign rd_word = mem[raddr];
  end else begin : gen_auto
    logic [DATA_WIDTH-1:0] mem [WORDS];
    always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
    assign rd_word = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (load) dout <= bypass ? wdata : rd_word;
  end

endmodule

// File: rtl/gmem_m_axi_fifo_flex.sv
// First-word-fall-through FIFO for the m_axi adapter paths.
//   clk, reset (sync, active-high), clk_en (freezes all state), flush (clears contents)
//   if_write/if_din/if_full_n       write side
//   if_read/if_dout/if_empty_n      read side, if_dout registered
//   if_num_data_valid               words held, 0..DEPTH
//   if_almost_full/if_almost_empty  threshold flags on the count
//   err_overflow/err_underflow      sticky rejected-request flags, cleared by reset only
module gmem_m_axi_fifo_flex
  import gmem_m_axi_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter string       MEM_STYLE  = "auto",
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  output logic                  if_full_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam bit          IsSrl = (MEM_STYLE == MemStyleShiftreg);

  if (!params_ok(DEPTH, ADDR_WIDTH, AF_THRESH, AE_THRESH)) begin : gen_bad_params
    $error("gmem_m_axi_fifo_flex: invalid DEPTH/ADDR_WIDTH/AF_THRESH/AE_THRESH");
  end

  logic [CntW-1:0] count_q, count_d, ring_cnt;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_raddr;
  logic            empty_n_q, empty_n_d, full_n_q, full_n_d;
  logic            af_q, af_d, ae_q, ae_d, ovf_q, ovf_d, unf_q, unf_d;
  logic            push, pop, ring_empty, bypass, ring_wr, refill, load;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 2)) ? '0 : p + PtrW'(1);
  endfunction

  assign push       = if_write & full_n_q & ~flush;
  assign pop        = if_read & empty_n_q & ~flush;
  assign ring_cnt   = count_q - CntW'(empty_n_q);
  assign ring_empty = (ring_cnt == '0);
  // Output register is free this cycle when it holds nothing or is being popped.
  assign bypass     = push & ring_empty & (~empty_n_q | pop);
  assign ring_wr    = push & ~bypass;
  assign refill     = ~ring_empty & (~empty_n_q | pop);
  assign load       = bypass | refill;
  assign ram_raddr  = IsSrl ? PtrW'(ring_cnt - CntW'(1)) : rd_ptr_q;

  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    empty_n_d = empty_n_q;
    if (flush) begin
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      empty_n_d = 1'b0;
    end else begin
      count_d   = count_q + CntW'(push) - CntW'(pop);
      empty_n_d = (empty_n_q & ~pop) | load;
      if (ring_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (refill)  rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    full_n_d = (count_d != CntW'(DEPTH));
    af_d     = (count_d >= CntW'(AF_THRESH));
    ae_d     = (count_d <= CntW'(AE_THRESH));
    ovf_d    = ovf_q | (if_write & ~full_n_q & ~flush);
    unf_d    = unf_q | (if_read & ~empty_n_q & ~flush);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else if (clk_en) begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  gmem_m_axi_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS      (DEPTH - 1),
    .PTR_WIDTH  (PtrW),
    .MEM_STYLE  (MEM_STYLE)
  ) u_ram (
    .clk    (clk),
    .we     (ring_wr & clk_en & ~reset),
    .waddr  (wr_ptr_q),
    .wdata  (if_din),
    .load   (load & clk_en & ~reset),
    .bypass (bypass),
    .raddr  (ram_raddr),
    .dout   (if_dout)
  );

  assign if_full_n         = full_n_q;
  assign if_empty_n        = empty_n_q;
  assign if_num_data_valid = count_q;
  assign if_almost_full    = af_q;
  assign if_almost_empty   = ae_q;
  assign err_overflow      = ovf_q;
  assign err_underflow     = unf_q;

endmodule

// File: tb/tb_gmem_m_axi_fifo_flex.sv
// Directed bench for gmem_m_axi_fifo_flex at DEPTH=5, AF_THRESH=4, AE_THRESH=1.
module tb_gmem_m_axi_fifo_flex;

  logic       clk = 1'b0;
  logic       reset, clk_en, flush, if_write, if_read;
  logic [7:0] if_din, if_dout;
  logic       if_full_n, if_empty_n, if_almost_full, if_almost_empty;
  logic       err_overflow, err_underflow;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gmem_m_axi_fifo_flex #(
    .DATA_WIDTH (8),
    .DEPTH      (5),
    .ADDR_WIDTH (3),
    .MEM_STYLE  ("auto"),
    .AF_THRESH  (4),
    .AE_THRESH  (1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .clk_en            (clk_en),
    .flush             (flush),
    .if_full_n         (if_full_n),
    .if_write          (if_write),
    .if_din            (if_din),
    .if_empty_n        (if_empty_n),
    .if_read           (if_read),
    .if_dout           (if_dout),
    .if_num_data_valid (count),
    .if_almost_full    (if_almost_full),
    .if_almost_empty   (if_almost_empty),
    .err_overflow      (err_overflow),
    .err_underflow     (err_underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b1; flush = 1'b0; if_write = 1'b0; if_read = 1'b0; if_din = '0;
    tick(); tick();
    reset = 1'b0;
    n_checks++;
    if ({if_full_n, if_empty_n, if_almost_full, if_almost_empty} !== 4'b1001) begin
      n_fail++;
      $display("FAIL reset_flags: got full_n/empty_n/af/ae=%b required 1001",
               {if_full_n, if_empty_n, if_almost_full, if_almost_empty});
    end
    n_checks++;
    if (count !== 4'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d required 0", count);
    end
    n_checks++;
    if ({err_overflow, err_underflow} !== 2'b00) begin
      n_fail++; $display("FAIL reset_err: got %b required 00", {err_overflow, err_underflow});
    end
  endtask

  task automatic test_fill_drain();
    if_write = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if_din = 8'(8'h0F + i);
      tick();
      n_checks++;
      if (count !== 4'(i)) begin
        n_fail++; $display("FAIL fill_count[%0d]: got %0d required %0d", i, count, i);
      end
      n_checks++;
      if ({if_full_n, if_empty_n, if_almost_full, if_almost_empty} !==
          {i < 5, 1'b1, i >= 4, i <= 1}) begin
        n_fail++;
        $display("FAIL fill_flags[%0d]: got full_n/empty_n/af/ae=%b required %b", i,
                 {if_full_n, if_empty_n, if_almost_full, if_almost_empty},
                 {i < 5, 1'b1, i >= 4, i <= 1});
      end
    end
    if_write = 1'b0;
    if_read  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (if_dout !== 8'(8'h10 + i)) begin
        n_fail++; $display("FAIL drain_data[%0d]: got %h required %h", i, if_dout, 8'(8'h10 + i));
      end
      tick();
      n_checks++;
      if ({count, if_empty_n, if_almost_empty} !== {4'(4 - i), i < 4, (4 - i) <= 1}) begin
        n_fail++;
        $display("FAIL drain_state[%0d]: got count/empty_n/ae=%0d/%b/%b required %0d/%b/%b", i,
                 count, if_empty_n, if_almost_empty, 4 - i, i < 4, (4 - i) <= 1);
      end
    end
    if_read = 1'b0;
  endtask

  task automatic test_bypass();
    if_write = 1'b1; if_din = 8'hA5;
    tick();
    if_write = 1'b0;
    n_checks++;
    if ({if_empty_n, if_dout, count} !== {1'b1, 8'hA5, 4'd1}) begin
      n_fail++;
      $display("FAIL bypass: got empty_n/dout/count=%b/%h/%0d required 1/a5/1",
               if_empty_n, if_dout, count);
    end
    if_read = 1'b1;
    tick();
    if_read = 1'b0;
    n_checks++;
    if ({if_empty_n, count} !== {1'b0, 4'd0}) begin
      n_fail++; $display("FAIL bypass_pop: got empty_n/count=%b/%0d required 0/0", if_empty_n, count);
    end
  endtask

  task automatic test_streaming();
    logic [7:0] wv, rv;
    wv = 8'h40; rv = 8'h40;
    if_write = 1'b1;
    repeat (3) begin if_din = wv; tick(); wv++; end
    if_read = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if_din = wv;
      n_checks++;
      if (if_dout !== rv) begin
        n_fail++; $display("FAIL stream_data[%0d]: got %h required %h", i, if_dout, rv);
      end
      n_checks++;
      if ({count, if_empty_n, if_full_n} !== {4'd3, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL stream_state[%0d]: got count/empty_n/full_n=%0d/%b/%b required 3/1/1", i,
                 count, if_empty_n, if_full_n);
      end
      tick(); wv++; rv++;
    end
    if_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (if_dout !== rv) begin
        n_fail++; $display("FAIL stream_tail[%0d]: got %h required %h", i, if_dout, rv);
      end
      tick(); rv++;
    end
    if_read = 1'b0;
    n_checks++;
    if (if_empty_n !== 1'b0) begin
      n_fail++; $display("FAIL stream_empty: got empty_n=%b required 0", if_empty_n);
    end
  endtask

  task automatic test_errors();
    if_write = 1'b1;
    for (int i = 0; i < 5; i++) begin if_din = 8'(8'h20 + i); tick(); end
    n_checks++;
    if (err_overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_early: got %b required 0", err_overflow);
    end
    if_din = 8'hEE;
    tick();
    if_write = 1'b0;
    n_checks++;
    if ({err_overflow, count, if_full_n} !== {1'b1, 4'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL overflow: got ovf/count/full_n=%b/%0d/%b required 1/5/0",
               err_overflow, count, if_full_n);
    end
    if_read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (if_dout !== 8'(8'h20 + i)) begin
        n_fail++; $display("FAIL ovf_intact[%0d]: got %h required %h", i, if_dout, 8'(8'h20 + i));
      end
      tick();
    end
    n_checks++;
    if (err_underflow !== 1'b0) begin
      n_fail++; $display("FAIL unf_early: got %b required 0", err_underflow);
    end
    tick();
    if_read = 1'b0;
    n_checks++;
    if ({err_underflow, count} !== {1'b1, 4'd0}) begin
      n_fail++; $display("FAIL underflow: got unf/count=%b/%0d required 1/0", err_underflow, count);
    end
    flush = 1'b1; tick(); flush = 1'b0;
    n_checks++;
    if ({err_overflow, err_underflow} !== 2'b11) begin
      n_fail++; $display("FAIL flush_keeps_err: got %b required 11", {err_overflow, err_underflow});
    end
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++;
    if ({err_overflow, err_underflow} !== 2'b00) begin
      n_fail++; $display("FAIL reset_clears_err: got %b required 00", {err_overflow, err_underflow});
    end
  endtask

  task automatic test_flush();
    if_write = 1'b1;
    for (int i = 0; i < 3; i++) begin if_din = 8'(8'h30 + i); tick(); end
    if_din = 8'h99; flush = 1'b1;
    tick();
    flush = 1'b0; if_write = 1'b0;
    n_checks++;
    if ({count, if_empty_n, if_full_n, if_almost_full, if_almost_empty} !==
        {4'd0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_state: got count/empty_n/full_n/af/ae=%0d/%b/%b/%b/%b required 0/0/1/0/1",
               count, if_empty_n, if_full_n, if_almost_full, if_almost_empty);
    end
    if_write = 1'b1; if_din = 8'h77;
    tick();
    if_write = 1'b0;
    n_checks++;
    if ({if_empty_n, if_dout, count} !== {1'b1, 8'h77, 4'd1}) begin
      n_fail++;
      $display("FAIL flush_rewrite: got empty_n/dout/count=%b/%h/%0d required 1/77/1",
               if_empty_n, if_dout, count);
    end
    if_read = 1'b1; tick(); if_read = 1'b0;
    n_checks++;
    if (if_empty_n !== 1'b0) begin
      n_fail++; $display("FAIL flush_drain: got empty_n=%b required 0", if_empty_n);
    end
  endtask

  task automatic test_clk_en();
    logic [7:0] wv, rv;
    wv = 8'h60; rv = 8'h60;
    if_write = 1'b1;
    repeat (2) begin if_din = wv; tick(); wv++; end
    if_read = 1'b1;
    repeat (3) begin if_din = wv; tick(); wv++; rv++; end
    clk_en = 1'b0; if_din = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({if_dout, count, if_empty_n, if_full_n} !== {rv, 4'd2, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL clken_hold[%0d]: got dout/count/empty_n/full_n=%h/%0d/%b/%b required %h/2/1/1",
                 i, if_dout, count, if_empty_n, if_full_n, rv);
      end
    end
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_din = wv;
      n_checks++;
      if (if_dout !== rv) begin
        n_fail++; $display("FAIL clken_resume[%0d]: got %h required %h", i, if_dout, rv);
      end
      tick(); wv++; rv++;
    end
    if_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (if_dout !== rv) begin
        n_fail++; $display("FAIL clken_tail[%0d]: got %h required %h", i, if_dout, rv);
      end
      tick(); rv++;
    end
    if_read = 1'b0;
    n_checks++;
    if ({if_empty_n, count, err_underflow} !== {1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL clken_end: got empty_n/count/unf=%b/%0d/%b required 0/0/0",
               if_empty_n, count, err_underflow);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_bypass();
    test_streaming();
    test_errors();
    test_flush();
    test_clk_en();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
